// File: rtl/ibus_dual_fetch_bridge_pkg.sv
// Shared types for the instruction-side dual-word fetch bridge.
// Bus bundles and bridge state encoding.
package ibus_dual_fetch_bridge_pkg;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [2:0] {
        IB_IDLE,
        IB_REQ1,
        IB_REQ2,
        IB_WAIT,
        IB_DONE,
        IB_DRAIN
    } ibridge_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } flex_bus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data_1;
        logic [31:0] data_2;
        logic        valid_2;
    } flex_bus_resp_t;

    function automatic logic [31:0] next_word(input logic [31:0] a);
        return a + WORD_BYTES;
    endfunction

endpackage

// File: rtl/ibus_dual_fetch_bridge_if.sv
// Fetch-side request/response plus SRAM-like inst bus.
// slave = bridge view, master = fetch/memory view.
interface ibus_dual_fetch_bridge_if;
    import ibus_dual_fetch_bridge_pkg::*;

    flex_bus_req_t  ireq;
    flex_bus_resp_t iresp;
    logic           inst_req;
    logic [31:0]    inst_addr;
    logic           inst_addr_ok;
    logic           inst_data_ok;
    logic [31:0]    inst_rdata;

    modport slave (
        input  ireq,
        output iresp,
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport master (
        output ireq,
        input  iresp,
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/ibus_dual_fetch_bridge_resp_collect.sv
// Outstanding-read counter and per-transaction response capture.
// Responses with nothing outstanding are dropped.
module ibus_resp_collect (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        fire_i,
    input  logic        data_ok_i,
    input  logic        need2_i,
    input  logic [31:0] rdata_i,
    output logic [1:0]  pend_d_o,
    output logic [1:0]  cnt_d_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o
);
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] d1_q, d1_d;
    logic [31:0] d2_q, d2_d;
    logic        take;

    assign take = data_ok_i && (pend_q != 2'd0);

    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        if (fire_i && !take)
            pend_d = pend_q + 2'd1;
        else if (take && !fire_i)
            pend_d = pend_q - 2'd1;
        if (clear_i) begin
            cnt_d = 2'd0;
            d1_d  = 32'd0;
            d2_d  = 32'd0;
        end else if (take) begin
            if (cnt_q == 2'd0)
                d1_d = rdata_i;
            else if (cnt_q == 2'd1 && need2_i)
                d2_d = rdata_i;
            if (cnt_q != 2'd3)
                cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 2'd0;
            cnt_q  <= 2'd0;
            d1_q   <= 32'd0;
            d2_q   <= 32'd0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
        end
    end

    assign pend_d_o = pend_d;
    assign cnt_d_o  = cnt_d;
    assign data1_o  = d1_q;
    assign data2_o  = d2_q;

endmodule

// File: rtl/ibus_dual_fetch_bridge.sv
// Fetch bridge: one request becomes one or two inst-bus reads,
// returned together; withdrawn requests drain their responses.
module ibus_dual_fetch_bridge
    import ibus_dual_fetch_bridge_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter bit          DUAL_EN    = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    ibus_dual_fetch_bridge_if.slave   bus
);
    localparam int unsigned IDXW = $clog2(LINE_WORDS);

    ibridge_state_t state_q, state_d;
    logic [31:0]    a_q, a_d;
    logic           need2_q, need2_d;
    logic           abort_q, abort_d;
    logic           need2_new;
    logic           accept;
    logic           req;
    logic [31:0]    req_addr;
    logic           fire;
    logic [1:0]     pend_d;
    logic [1:0]     cnt_d;
    logic [31:0]    data1, data2;
    flex_bus_resp_t resp;

    assign need2_new = DUAL_EN &&
        (bus.ireq.addr[2 +: IDXW] != IDXW'(LINE_WORDS - 1));
    assign fire = req && bus.inst_addr_ok;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        need2_d  = need2_q;
        abort_d  = abort_q;
        accept   = 1'b0;
        req      = 1'b0;
        req_addr = 32'd0;
        resp     = '0;
        unique case (state_q)
            IB_IDLE: begin
                if (bus.ireq.valid) begin
                    accept  = 1'b1;
                    a_d     = bus.ireq.addr;
                    need2_d = need2_new;
                    abort_d = 1'b0;
                    state_d = IB_REQ1;
                end
            end
            IB_REQ1: begin
                req      = 1'b1;
                req_addr = a_q;
                if (!bus.ireq.valid)
                    abort_d = 1'b1;
                if (bus.inst_addr_ok) begin
                    resp.addr_ok = 1'b1;
                    if (abort_q || !bus.ireq.valid)
                        state_d = IB_DRAIN;
                    else if (need2_q)
                        state_d = IB_REQ2;
                    else
                        state_d = IB_WAIT;
                end
            end
            IB_REQ2: begin
                req      = 1'b1;
                req_addr = next_word(a_q);
                if (!bus.ireq.valid)
                    abort_d = 1'b1;
                if (bus.inst_addr_ok)
                    state_d = (abort_q || !bus.ireq.valid) ?
                              IB_DRAIN : IB_WAIT;
            end
            IB_WAIT: begin
                // withdrawal wins over a completion in the same cycle
                if (!bus.ireq.valid)
                    state_d = IB_DRAIN;
                else if (cnt_d == (need2_q ? 2'd2 : 2'd1))
                    state_d = IB_DONE;
            end
            IB_DONE: begin
                resp.data_ok = 1'b1;
                resp.data_1  = data1;
                resp.data_2  = data2;
                resp.valid_2 = need2_q;
                state_d      = IB_IDLE;
            end
            IB_DRAIN: begin
                if (pend_d == 2'd0)
                    state_d = IB_IDLE;
            end
            default: state_d = IB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IB_IDLE;
            a_q     <= 32'd0;
            need2_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            need2_q <= need2_d;
            abort_q <= abort_d;
        end
    end

    ibus_resp_collect u_collect (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept),
        .fire_i    (fire),
        .data_ok_i (bus.inst_data_ok),
        .need2_i   (need2_q),
        .rdata_i   (bus.inst_rdata),
        .pend_d_o  (pend_d),
        .cnt_d_o   (cnt_d),
        .data1_o   (data1),
        .data2_o   (data2)
    );

    assign bus.inst_req  = req;
    assign bus.inst_addr = req_addr;
    assign bus.iresp     = resp;

endmodule

// File: tb/tb_ibus_dual_fetch_bridge.sv
// Bench for ibus_dual_fetch_bridge: directed scenarios plus random
// traffic against a memory model and an expected-response queue.
module tb_ibus_dual_fetch_bridge;
    import ibus_dual_fetch_bridge_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ibus_dual_fetch_bridge_if bus();

    ibus_dual_fetch_bridge #(
        .LINE_WORDS (8),
        .DUAL_EN    (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        v2;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aok_pulses = 0;
    int hs_cnt = 0;
    int min_aok = 0;
    int max_aok = 0;
    int dok_pct = 100;
    bit inject_stray = 1'b0;
    exp_t expq[$];
    logic [31:0] sq[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hbfc0_0000) return 32'h2401_0001;
        if (a == 32'hbfc0_0004) return 32'h2402_0002;
        return (a * 32'h9e37_79b1) ^ 32'h1234_5678;
    endfunction

    // second word exists unless A is the last word of its 8-word line
    function automatic bit need2_ref(input logic [31:0] a);
        return ((a >> 2) % 8) != 7;
    endfunction

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // SRAM-like memory: programmable accept delay, in-order data
    initial begin : slave
        int wcnt;
        int dly;
        logic [31:0] last_addr;
        wcnt = 0;
        dly = 0;
        last_addr = 32'd0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata = 32'd0;
        forever begin
            @(posedge clk);
            if (bus.inst_addr_ok) begin
                sq.push_back(last_addr);
                hs_cnt++;
            end
            #1;
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            if (sq.size() > 0 && $urandom_range(99) < dok_pct) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata = mem(sq.pop_front());
            end else if (inject_stray) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata = 32'hdead_beef;
                inject_stray = 1'b0;
            end
            if (bus.inst_req) begin
                if (wcnt == 0)
                    dly = $urandom_range(max_aok, min_aok);
                if (wcnt >= dly) begin
                    bus.inst_addr_ok = 1'b1;
                    last_addr = bus.inst_addr;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // monitor: response scoreboard and request-hold protocol
    initial begin : monitor
        bit prev_req;
        bit prev_aok;
        logic [31:0] prev_addr;
        exp_t e;
        prev_req = 1'b0;
        prev_aok = 1'b0;
        prev_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
                continue;
            end
            if (prev_req && !prev_aok) begin
                check("req_hold", {bus.inst_req, bus.inst_addr},
                      {1'b1, prev_addr});
            end
            prev_req = bus.inst_req;
            prev_aok = bus.inst_addr_ok;
            prev_addr = bus.inst_addr;
            if (bus.iresp.addr_ok) aok_pulses++;
            if (bus.iresp.data_ok) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_ok actual=1 required=0");
                end else begin
                    e = expq.pop_front();
                    check("data_1", bus.iresp.data_1, e.d1);
                    check("data_2", bus.iresp.data_2, e.d2);
                    check("valid_2", bus.iresp.valid_2, e.v2);
                end
            end else begin
                check("resp_idle", {bus.iresp.data_1, bus.iresp.data_2,
                      bus.iresp.valid_2}, 96'd0);
            end
        end
    end

    // abort_at = 0: normal transaction; n: drop valid n cycles after addr_ok
    task automatic txn(input logic [31:0] a, input int abort_at,
                       output int lat);
        int t0;
        int n0;
        bit got;
        lat = -1;
        bus.ireq.addr = a;
        bus.ireq.valid = 1'b1;
        t0 = cyc;
        n0 = aok_pulses;
        if (abort_at == 0)
            expq.push_back('{mem(a), need2_ref(a) ? mem(a + 4) : 32'd0,
                             need2_ref(a)});
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = bus.iresp.addr_ok;
        end
        if (!got) begin
            check("addr_ok_timeout", 1'b0, 1'b1);
            bus.ireq.valid = 1'b0;
            return;
        end
        if (abort_at != 0) begin
            repeat (abort_at) @(posedge clk);
            #1;
            bus.ireq.valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = bus.iresp.data_ok;
        end
        if (!got) begin
            check("data_ok_timeout", 1'b0, 1'b1);
        end else begin
            lat = cyc - t0;
            check("addr_ok_once", aok_pulses - n0, 1);
        end
        @(posedge clk);
        #1;
        bus.ireq.valid = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check(name, {bus.inst_req, bus.iresp}, 96'd0);
    endtask

    initial begin : stim
        int lat;
        int h0;
        bit got;
        bus.ireq.valid = 1'b0;
        bus.ireq.addr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("reset_state");

        // single word at the end of a line
        @(posedge clk); #1;
        h0 = hs_cnt;
        txn(32'hbfc0_001c, 0, lat);
        check("lat_single", lat, 3);
        check("hs_single", hs_cnt - h0, 1);

        // two words, same-cycle accept of A+4 and data for A
        h0 = hs_cnt;
        txn(32'hbfc0_0000, 0, lat);
        check("lat_dual", lat, 4);
        check("hs_dual", hs_cnt - h0, 2);

        // stalled address acceptance
        min_aok = 3; max_aok = 3;
        txn(32'hbfc0_001c, 0, lat);
        txn(32'hbfc0_0008, 0, lat);

        // withdrawal while REQ1 is still stalled: no REQ2, no data
        h0 = hs_cnt;
        bus.ireq.addr = 32'hbfc0_0040;
        bus.ireq.valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.ireq.valid = 1'b0;
        repeat (20) @(posedge clk);
        check("hs_req1_abort", hs_cnt - h0, 1);
        min_aok = 0; max_aok = 0;

        // withdrawal in WAIT with both responses outstanding
        dok_pct = 0;
        txn(32'hbfc0_0000, 2, lat);
        repeat (4) @(posedge clk);
        dok_pct = 100;
        #1;
        txn(32'hbfc0_0100, 0, lat);

        // reset with one response outstanding, then stray responses
        dok_pct = 0;
        bus.ireq.addr = 32'hbfc0_003c;
        bus.ireq.valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus.iresp.addr_ok;
        end
        check("rst_addr_ok", got, 1'b1);
        @(posedge clk); #1;
        bus.ireq.valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("reset_mid_op");
        dok_pct = 100;
        inject_stray = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_quiet("after_stray");
        @(posedge clk); #1;
        txn(32'hbfc0_0020, 0, lat);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            max_aok = $urandom_range(2);
            dok_pct = $urandom_range(100, 40);
            txn(32'hbfc0_0000 + 32'($urandom_range(63)) * 4,
                ($urandom_range(4) == 0) ? 1 : 0, lat);
        end
        dok_pct = 100;
        repeat (20) @(posedge clk);
        check("exp_queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
